// File: rtl/spi_shift_ctrl.sv
// SPI mode-0 byte master behind a CPU register window (DATA/CTRL).
// Stalls the CPU acknowledge while a byte is shifting, giving blocking byte semantics.
module spi_shift_ctrl #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        CPU_CLK,
    input  logic        RESET,
    input  logic        REQ,
    input  logic        RW,
    input  logic        REG,
    input  logic [15:0] WDATA,
    output logic [15:0] RDATA,
    output logic        ACK_N,
    output logic        BUSY,
    output logic        SPI_CS,
    output logic        SPI_SCK,
    output logic        SPI_MOSI,
    input  logic        SPI_MISO
);

    typedef enum logic {IDLE, SHIFT} state_e;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_e      state_q, state_d;
    logic        served_q, served_d;
    logic        ack_n_q, ack_n_d;
    logic [15:0] rdata_q, rdata_d;
    logic        cs_q, cs_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  div_q, div_d;

    logic busy, wrap, finish, accept;

    always_ff @(posedge CPU_CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            served_q  <= 1'b0;
            ack_n_q   <= 1'b1;
            rdata_q   <= '0;
            cs_q      <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_byte_q <= '0;
            bit_q     <= '0;
            div_q     <= '0;
        end else begin
            state_q   <= state_d;
            served_q  <= served_d;
            ack_n_q   <= ack_n_d;
            rdata_q   <= rdata_d;
            cs_q      <= cs_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_byte_q <= rx_byte_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        served_d  = served_q;
        ack_n_d   = ack_n_q;
        rdata_d   = rdata_q;
        cs_d      = cs_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_byte_d = rx_byte_q;
        bit_d     = bit_q;
        div_d     = div_q;

        busy   = (state_q == SHIFT);
        wrap   = (div_q == DIV_LAST);
        // The last falling edge frees the engine on this very edge, so a stalled access can land here too.
        finish = busy && wrap && sck_q && (bit_q == 3'd7);
        accept = REQ && !served_q && (!busy || finish || (REG && RW));

        if (busy) begin
            if (wrap) begin
                div_d = '0;
                if (!sck_q) begin
                    sck_d = 1'b1;
                    rx_d  = {rx_q[6:0], SPI_MISO};
                end else begin
                    sck_d = 1'b0;
                    if (bit_q == 3'd7) begin
                        rx_byte_d = rx_q;
                        mosi_d    = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        mosi_d = tx_q[3'd6 - bit_q];
                    end
                end
            end else begin
                div_d = div_q + 8'd1;
            end
        end

        if (!REQ) begin
            served_d = 1'b0;
            ack_n_d  = 1'b1;
        end else if (accept) begin
            served_d = 1'b1;
            ack_n_d  = 1'b0;
            unique case ({REG, RW})
                2'b00: begin
                    tx_d    = WDATA[7:0];
                    bit_d   = '0;
                    div_d   = '0;
                    mosi_d  = WDATA[7];
                    sck_d   = 1'b0;
                    state_d = SHIFT;
                end
                2'b01:   rdata_d = {8'h00, finish ? rx_q : rx_byte_q};
                2'b10:   cs_d    = WDATA[15];
                default: rdata_d = {busy, 14'b0, cs_q};
            endcase
        end
    end

    assign RDATA    = rdata_q;
    assign ACK_N    = ack_n_q;
    assign BUSY     = (state_q == SHIFT);
    assign SPI_CS   = cs_q;
    assign SPI_SCK  = sck_q;
    assign SPI_MOSI = mosi_q;

endmodule

// File: doc/spi_shift_ctrl.md
# spi_shift_ctrl

Hardware SPI master that replaces the bit-banged SPI port behind the autoconfigured SPI board range. It shifts a full byte (mode 0, MSB first) per CPU write and holds the received byte for readback. It owns SPI_CS, SPI_SCK and SPI_MOSI, and answers CPU accesses with its own active-low acknowledge. The acknowledge is stalled while a transfer is in flight, so software gets blocking byte semantics without polling.

## Interface
- CLK_DIV, 4: SCK half-period in CPU_CLK cycles; legal range 1..255.
- CPU_CLK  input  1  sole clock; all state on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- REQ  input  1  CPU access to SPI range, qualified by address decode, /AS and /DS; held high for the whole bus cycle.
- RW  input  1  1 = read, 0 = write; valid while REQ is high.
- REG  input  1  register select (ADDRESS[1]): 0 = DATA, 1 = CTRL.
- WDATA  input  16  CPU write data.
- RDATA  output  16  read data; valid while ACK_N is low.
- ACK_N  output  1  active-low cycle acknowledge, ANDed into CPU_DTACK by the top level.
- BUSY  output  1  transfer in progress.
- SPI_CS  output  1  chip select, software controlled.
- SPI_SCK  output  1  serial clock (CPOL=0).
- SPI_MOSI  output  1  serial data out.
- SPI_MISO  input  1  serial data in; synchronised externally.

## Operation
- States: IDLE, SHIFT.
- The access is accepted once per REQ assertion. A served flag is set at acceptance and cleared when REQ is low.
- Accept condition: REQ=1, served=0, and either state=IDLE or the access is a CTRL read. Otherwise the access stalls with ACK_N held high.
- DATA write (IDLE): load tx shift register with WDATA[7:0], clear bit counter and divider, set MOSI=WDATA[7] and SCK=0, go to SHIFT.
- DATA read (IDLE): RDATA = {8'h00, rx_byte}.
- CTRL write (IDLE): SPI_CS <= WDATA[15]. Other bits are ignored.
- CTRL read (any state): RDATA = {BUSY, 14'b0, SPI_CS}. It is never stalled.
- SHIFT behaviour:
  - The divider counts 0..CLK_DIV-1. At the wrap it toggles phase.
  - Low→high toggle: SCK=1, rx shift register <= {rx[6:0], SPI_MISO}.
  - High→low toggle: SCK=0.
    - If bit counter = 7: rx_byte <= rx shift register, MOSI=0, go to IDLE.
    - Otherwise: bit counter +1, MOSI = next tx bit (MSB first).
- SPI_CS is never changed by the engine. A CS write during SHIFT stalls until IDLE, so CS cannot glitch mid-byte.
- Simultaneous events:
  - A stalled access that becomes acceptable is accepted on the same edge SHIFT→IDLE completes. The new DATA write therefore starts a back-to-back transfer with no idle SCK period beyond that one edge.
  - A stalled DATA read returns the just-completed byte.
- REQ dropping before acceptance cancels the access. There are no side effects, and no pending state is kept.
- Reset values (asynchronous, any state including mid-transfer): state IDLE, SPI_CS=1, SPI_SCK=0, SPI_MOSI=0, BUSY=0, ACK_N=1, RDATA=0, rx_byte=0, counters=0, served=0. A mid-byte reset truncates the transfer; the slave sees CS rise.

## Timing
- Acceptance edge t: ACK_N falls at t, registered and visible after edge t. ACK_N rises on the first edge where REQ=0.
- RDATA is registered at t and stable while ACK_N is low.
- DATA write at t:
  - BUSY=1 and MOSI=bit7 after t.
  - SCK rises at t+CLK_DIV; MISO is sampled on that edge.
  - SCK falls at t+2·CLK_DIV.
  - Bit n rises at t+(2n+1)·CLK_DIV.
  - Final fall and BUSY=0 at t+16·CLK_DIV.
- MOSI changes only on SCK falling edges or at load, giving a CLK_DIV-cycle setup before each rising edge.
- CLK_DIV=1: SCK toggles every CPU_CLK; a byte takes 16 cycles.
- A stalled access is acknowledged at the edge where BUSY falls. CPU wait time equals the remaining transfer cycles.

## Test plan
- Reset: assert RESET mid-SHIFT (CLK_DIV=4, bit 3) → same-instant SPI_CS=1, SCK=0, MOSI=0, BUSY=0, ACK_N=1; a following CTRL read returns 16'h0001.
- Single byte: CTRL write 16'h0000, then DATA write 16'h00A5 with MISO slave model returning 8'h3C, CLK_DIV=4 → 8 SCK pulses, MOSI bits 1,0,1,0,0,1,0,1 at rising edges; BUSY high 64 cycles; DATA read returns 16'h003C.
- Stall: DATA read issued 10 cycles after a DATA write starts (CLK_DIV=4) → ACK_N stays high until the BUSY-fall edge (54 cycles later), RDATA = received byte.
- Polling: CTRL read during SHIFT → ACK_N low one edge after REQ, RDATA = 16'h8000 with CS low; after completion → 16'h0000.
- Back-to-back: second DATA write 16'h00FF held stalled → first byte ends and second starts on the same edge; SCK low for exactly CLK_DIV cycles between bytes.
- Abort/CS guard: CTRL write 16'h8000 during SHIFT, REQ dropped after 5 cycles → no ACK_N, SPI_CS stays 0, transfer completes normally; CLK_DIV=1 run → 16-cycle byte.
